alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_mul_iter.sv | 50 +++++
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op_code constants and FSM state type for alu_pipe
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand and result channels of alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [3:0]       op_code;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             overflow;
    logic             equal;
    logic             zero;
    logic             illegal;

    modport slave (
        input  in_valid, X, Y, op_code, out_ready,
        output in_ready, out_valid, Z, overflow, equal, zero, illegal
    );

    modport master (
        output in_valid, X, Y, op_code, out_ready,
        input  in_ready, out_valid, Z, overflow, equal, zero, illegal
    );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add unsigned multiplier, one multiplier bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               take,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic               running;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    // Last partial product is added combinationally so the result is ready in the WIDTH-th cycle.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= SHW'(WIDTH - 1);
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            if (cnt != '0) begin
                acc    <= product;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end else if (take) begin
                running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU; ALU_MUL_EN adds the iterative MUL on op 4
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic             out_valid;
    logic [WIDTH-1:0] z_q;
    logic             ovf_q, eq_q, zero_q, ill_q;
    logic             accept, is_mul;
    logic [WIDTH-1:0] res, sum, diff;
    logic             res_ovf, res_ill;
    logic [SHW-1:0]   sh;

    assign bus.in_ready  = (state == IDLE) && (!out_valid || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Z         = z_q;
    assign bus.overflow  = ovf_q;
    assign bus.equal     = eq_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = ill_q;

    assign sh   = bus.X[SHW-1:0];
    assign sum  = bus.X + bus.Y;
    assign diff = bus.X - bus.Y;

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        unique case (bus.op_code)
            OP_AND: res = bus.X & bus.Y;
            OP_OR:  res = bus.X | bus.Y;
            OP_XOR: res = bus.X ^ bus.Y;
            OP_NOR: res = ~(bus.X | bus.Y);
            OP_ADD: begin
                res     = sum;
                res_ovf = (bus.X[WIDTH-1] == bus.Y[WIDTH-1]) && (sum[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (bus.X[WIDTH-1] != bus.Y[WIDTH-1]) && (diff[WIDTH-1] != bus.X[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.X) < $signed(bus.Y))};
            OP_SRL: res = bus.Y >> sh;
            OP_SLL: res = bus.Y << sh;
            OP_SRA: res = $unsigned($signed(bus.Y) >>> sh);
`ifdef ALU_MUL_EN
            OP_MUL: res = '0;
`endif
            default: res_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic               mul_done, mul_load, mul_eq;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul   = (bus.op_code == OP_MUL);
    // A finished product waits in BUSY until the output register is free.
    assign mul_load = (state == BUSY) && mul_done && (!out_valid || bus.out_ready);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .take    (mul_load),
        .a       (bus.X),
        .b       (bus.Y),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul = 1'b0;
    assign state  = IDLE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z_q       <= '0;
            ovf_q     <= 1'b0;
            eq_q      <= 1'b0;
            zero_q    <= 1'b0;
            ill_q     <= 1'b0;
`ifdef ALU_MUL_EN
            state     <= IDLE;
            mul_eq    <= 1'b0;
`endif
        end else begin
            if (accept && !is_mul) begin
                out_valid <= 1'b1;
                z_q       <= res;
                ovf_q     <= res_ovf;
                eq_q      <= (bus.X == bus.Y);
                zero_q    <= (res == '0);
                ill_q     <= res_ill;
            end
`ifdef ALU_MUL_EN
            else if (mul_load) begin
                out_valid <= 1'b1;
                z_q       <= mul_prod[WIDTH-1:0];
                ovf_q     <= |mul_prod[2*WIDTH-1:WIDTH];
                eq_q      <= mul_eq;
                zero_q    <= (mul_prod[WIDTH-1:0] == '0);
                ill_q     <= 1'b0;
            end
`endif
            else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            case (state)
                IDLE: if (accept && is_mul) begin
                    state  <= BUSY;
                    mul_eq <= (bus.X == bus.Y);
                end
                BUSY: if (mul_load) state <= IDLE;
                default: state <= IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized self-checking bench for alu_pipe
module tb_alu_pipe;
    typedef struct packed {
        logic [31:0] z;
        logic        ovf;
        logic        eq;
        logic        zero;
        logic        ill;
    } res_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic res_t mk(logic [31:0] z, logic ovf, logic eq, logic zero, logic ill);
        res_t r;
        r.z = z; r.ovf = ovf; r.eq = eq; r.zero = zero; r.ill = ill;
        return r;
    endfunction

    function automatic res_t model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
        res_t            e;
        longint          sx, sy, s;
        longint unsigned p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = '0;
        e.eq = (x == y);
        case (op)
            4'd0: e.z = x & y;
            4'd1: e.z = x | y;
            4'd2: e.z = x ^ y;
            4'd3: e.z = ~(x | y);
            4'd5: begin s = sx + sy; e.z = 32'(s); e.ovf = (s > MAXS) || (s < MINS); end
            4'd6: begin s = sx - sy; e.z = 32'(s); e.ovf = (s > MAXS) || (s < MINS); end
            4'd7: e.z = (sx < sy) ? 32'd1 : 32'd0;
            4'd8: e.z = y >> x[4:0];
            4'd9: e.z = y << x[4:0];
            4'd10: e.z = 32'($signed(y) >>> x[4:0]);
`ifdef ALU_MUL_EN
            4'd4: begin
                p = 64'(x) * 64'(y);
                e.z = p[31:0];
                e.ovf = (p[63:32] != 0);
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.z == 0);
        return e;
    endfunction

    function automatic res_t observed();
        return mk(bus.Z, bus.overflow, bus.equal, bus.zero, bus.illegal);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input res_t e);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(tag, 64'(observed()), 64'(e));
    endtask

    // Inputs change just after a rising edge; pops and accepts are judged once they settle.
    task automatic cycle(input logic iv, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic ordy);
        bus.in_valid  = iv;
        bus.op_code   = op;
        bus.X         = x;
        bus.Y         = y;
        bus.out_ready = ordy;
        #2;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) check("sb_unexpected_pop", 64'(bus.out_valid && (sb.size() != 0)), 64'd1);
            else check("sb_result", 64'(observed()), 64'(sb.pop_front()));
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(model(op, x, y));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (bus.out_valid || sb.size() != 0); i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_outs"}, 64'(observed()), 64'(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        bus.in_valid = 1'b0; bus.op_code = 4'd0; bus.X = '0; bus.Y = '0; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        pulse_reset("reset");

        cycle(1'b1, 4'd5, 32'h7fffffff, 32'h1, 1'b1);
        check_out("add_ovf", mk(32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0));

        cycle(1'b1, 4'd6, 32'd5, 32'd5, 1'b1);
        check_out("sub_zero", mk(32'h0, 1'b0, 1'b1, 1'b1, 1'b0));
        cycle(1'b1, 4'd7, 32'hffffffff, 32'd2, 1'b1);
        check_out("slt", mk(32'h1, 1'b0, 1'b0, 1'b0, 1'b0));
        cycle(1'b1, 4'd10, 32'd1, 32'h80000000, 1'b1);
        check_out("sra", mk(32'hc0000000, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        cycle(1'b1, 4'd2, 32'hf0f0f0f0, 32'hffffffff, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'd0, 32'h1234, 32'h5678, 1'b0);
            check_out("hold_xor", mk(32'h0f0f0f0f, 1'b0, 1'b0, 1'b0, 1'b0));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        cycle(1'b1, 4'd1, 32'h12340000, 32'h00005678, 1'b1);
        check_out("replace_or", mk(32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0));

        cycle(1'b1, 4'd13, 32'd3, 32'd3, 1'b1);
        check_out("illegal13", mk(32'h0, 1'b0, 1'b1, 1'b1, 1'b1));
        drain();

`ifdef ALU_MUL_EN
        cycle(1'b1, 4'd4, 32'h10000, 32'h10000, 1'b1);
        k = 1;
        while (!bus.out_valid && k < 40) begin
            check("mul_busy_in_ready", 64'(bus.in_ready), 64'd0);
            cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
            k++;
        end
        check("mul_latency", 64'(k), 64'd33);
        check_out("mul_big", mk(32'h0, 1'b1, 1'b1, 1'b1, 1'b0));
        drain();
        cycle(1'b1, 4'd4, 32'd3, 32'd5, 1'b1);
        for (int i = 0; i < 40 && !bus.out_valid; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check_out("mul_3x5", mk(32'hf, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();
        cycle(1'b1, 4'd4, 32'd7, 32'd9, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        pulse_reset("mul_reset");
`else
        cycle(1'b1, 4'd4, 32'd1, 32'd2, 1'b1);
        check_out("illegal4", mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
        cycle(1'b1, 4'd3, 32'h0, 32'h0, 1'b0);
        pulse_reset("held_reset");
`endif
        cycle(1'b1, 4'd5, 32'd1, 32'd1, 1'b1);
        check_out("add_after_reset", mk(32'h2, 1'b0, 1'b1, 1'b0, 1'b0));
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            y = ($urandom_range(0, 7) == 0) ? x : $urandom;
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), x, y, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
